// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
package clk_div_pkg;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned HALF_500HZ = 100_000;
  localparam int unsigned HALF_1HZ   = 50_000_000;
  localparam int unsigned HALF_2HZ   = 25_000_000;

  // Half-period in clk cycles for a target output frequency; 0 Hz maps to P=0 (channel off).
  function automatic int unsigned half_of(input int unsigned hz);
    if (hz == 0) return 0;
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel: half-period counter, square wave, tick strobe
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_HALF = HALF_500HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             sq,
  output logic             tick,
  output logic             busy
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] half_nxt;
  logic [CNT_W-1:0] term;

  // busy tracks the divisor that will be in force after this edge
  assign half_nxt = load ? load_val : half;
  // P=0 is excluded before the compare, so the wrap of 0-1 is never used
  assign term     = half - CNT_W'(1);

  // Count, toggle and strobe; sync/write restart the count and override a terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      half  <= CNT_W'(DEF_HALF);
      sq    <= 1'b0;
      tick  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      busy <= en && (half_nxt != '0);
      if (load) begin
        half <= load_val;
      end
      if (clear || load) begin
        count <= '0;
        tick  <= 1'b0;
        if (clear) begin
          sq <= 1'b0;
        end
      end else if (!en || (half == '0)) begin
        count <= '0;
        sq    <= 1'b0;
        tick  <= 1'b0;
      end else if (count == term) begin
        count <= '0;
        sq    <= ~sq;
        tick  <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
        tick  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - N_CH independent programmable clock dividers with global sync
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_HALF = HALF_500HZ,
  localparam int         WR_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [WR_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_half,
  output logic [N_CH-1:0]  sq,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  logic [N_CH-1:0] load;

  // Channel index decode; an out-of-range wr_ch matches no channel and is dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load[i] = wr_en && (wr_ch == WR_W'(i));

    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .clear    (sync),
      .load     (load[i]),
      .load_val (wr_half),
      .sq       (sq[i]),
      .tick     (tick[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int          N_CH  = 5;
  localparam int          CNT_W = 32;
  localparam int unsigned DEF   = half_of(2_500_000);

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             wr_en;
  logic [2:0]       wr_ch;
  logic [CNT_W-1:0] wr_half;
  logic [N_CH-1:0]  sq;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] SYNC_TICK [12] = '{
    5'b00000, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b01010,
    5'b00000, 5'b00001, 5'b00010, 5'b00000, 5'b00000, 5'b01011};
  localparam logic [4:0] SYNC_SQ [12] = '{
    5'b00000, 5'b00000, 5'b00010, 5'b00011, 5'b00011, 5'b01001,
    5'b01001, 5'b01000, 5'b01010, 5'b01010, 5'b01010, 5'b00001};

  logic [9:1] p3_tick = 9'b100100100;
  logic [9:1] p3_sq   = 9'b100011100;

  clk_div_multi #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_half (wr_half),
    .sq      (sq),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] ch, input logic [CNT_W-1:0] p);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_half = p;
  endtask

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
    #1;
    check("rst_sq", 32'(sq), 32'(0));
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    step(); step();
    rst = 1'b0;
    en  = 5'h1F;

    // default half-period on every channel
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 1)  check("busy_on", 32'(busy), 32'h1F);
      if (e == 19) check("def_pre_tick", 32'(tick), 32'(0));
      if (e == 20) begin
        check("def_first_tick", 32'(tick), 32'h1F);
        check("def_first_sq", 32'(sq), 32'h1F);
      end
      if (e == 21) check("def_tick_1cyc", 32'(tick), 32'(0));
      if (e == 40) begin
        check("def_second_tick", 32'(tick), 32'h1F);
        check("def_second_sq", 32'(sq), 32'(0));
      end
    end

    // ch1 -> P=3 at edge 41
    write(3'd1, 32'd3);
    step();
    wr_en = 1'b0;
    check("p3_wr_tick", 32'(tick[1]), 32'(0));
    for (int k = 1; k <= 9; k++) begin
      step();
      check("p3_tick", 32'(tick[1]), 32'(p3_tick[k]));
      check("p3_sq", 32'(sq[1]), 32'(p3_sq[k]));
    end
    repeat (10) step();
    check("others_undisturbed", 32'(tick), 32'b11101);

    // mid-run shrink of ch2 (count 10 of 20) to P=5, then switch it off
    repeat (10) step();
    write(3'd2, 32'd5);
    step();
    wr_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("shrink_tick", 32'(tick[2]), 32'(k == 5));
    end
    write(3'd2, 32'd0);
    step();
    wr_en = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      check("off_sq", 32'(sq[2]), 32'(0));
      check("off_tick", 32'(tick[2]), 32'(0));
      check("off_busy", 32'(busy[2]), 32'(0));
    end

    // ch0 P=4, ch3 P=6, then sync together with a rewrite of ch0
    write(3'd0, 32'd4);
    step();
    write(3'd3, 32'd6);
    step();
    wr_en = 1'b0;
    repeat (7) step();
    sync = 1'b1;
    write(3'd0, 32'd4);
    step();
    sync  = 1'b0;
    wr_en = 1'b0;
    check("sync_sq", 32'(sq), 32'(0));
    check("sync_tick", 32'(tick), 32'(0));
    for (int k = 1; k <= 12; k++) begin
      step();
      check("sync_tick_seq", 32'(tick), 32'(SYNC_TICK[k-1]));
      check("sync_sq_seq", 32'(sq), 32'(SYNC_SQ[k-1]));
    end

    // drop en[0] for 7 cycles mid-period, then re-enable
    step(); step();
    en = 5'b11110;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("dis_sq", 32'(sq[0]), 32'(0));
      check("dis_tick", 32'(tick[0]), 32'(0));
      if (k == 1) check("dis_busy", 32'(busy), 32'b11010);
    end
    en = 5'h1F;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("reen_tick", 32'(tick[0]), 32'(k == 4));
    end

    // ch1 -> P=1 together with sync
    sync = 1'b1;
    write(3'd1, 32'd1);
    step();
    sync  = 1'b0;
    wr_en = 1'b0;
    check("p1_start_sq", 32'(sq), 32'(0));
    check("p1_start_tick", 32'(tick[1]), 32'(0));
    for (int k = 1; k <= 6; k++) begin
      step();
      check("p1_tick", 32'(tick[1]), 32'(1));
      check("p1_sq", 32'(sq[1]), 32'(k % 2));
    end

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_sq", 32'(sq), 32'(0));
    check("arst_tick", 32'(tick), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    step(); step();
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e < 20) check("oor_no_tick", 32'(tick), 32'(0));
      if (e == 20) begin
        check("revert_tick", 32'(tick), 32'h1F);
        check("revert_sq", 32'(sq), 32'h1F);
        check("revert_busy", 32'(busy), 32'h1F);
      end
      if (e == 4) write(3'd5, 32'd3);
      if (e == 5) wr_en = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
